// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared SPI definitions.
//   spi_mode_t       - the four CPOL/CPHA modes, encoded {cpol, cpha}
//   spi_state_t      - slave FSM state, also exported on the debug port
//   spi_mode()       - CPOL/CPHA to mode encoding
//   sample_on_rising - 1 when the sampling edge of sclk is the rising edge
//   change_on_rising - 1 when the shifting (change) edge is the rising edge
package spi_slave_pkg;

  typedef enum logic [1:0] {
    MODE0 = 2'd0,
    MODE1 = 2'd1,
    MODE2 = 2'd2,
    MODE3 = 2'd3
  } spi_mode_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_t;

  function automatic spi_mode_t spi_mode(input logic cpol, input logic cpha);
    return spi_mode_t'({cpol, cpha});
  endfunction

  // Data is sampled on the rising edge whenever CPOL and CPHA agree.
  function automatic logic sample_on_rising(input logic cpol, input logic cpha);
    return cpol == cpha;
  endfunction

  function automatic logic change_on_rising(input logic cpol, input logic cpha);
    return cpol != cpha;
  endfunction

endpackage

// File: rtl/spi_slave_if.sv
// spi_slave_if: user-side word interface of the SPI slave.
//   tx_data/tx_valid/tx_ready - word to send on MISO during the next transfer
//   rx_data/rx_valid/rx_ready - word received from MOSI
// Handshake: a word moves when valid and ready are both high at a rising
// clk edge; the producer holds valid (and data) stable until that edge, and
// ready may depend on nothing but the consumer's own state.
// Modports: slave = the SPI slave block, master = the user logic.
interface spi_slave_if #(
  parameter int DATA_WIDTH = 16
) ();

  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );

endinterface

// File: rtl/spi_slave_sync_edge.sv
// spi_slave_sync_edge: STAGES-deep synchronizer for an asynchronous input,
// followed by a registered copy of the synchronized level and registered
// rise/fall pulses (one clk cycle wide).
//   clk, rst  - system clock, synchronous active-high reset
//   d         - asynchronous input
//   q         - synchronized level (reset to RESET_VAL)
//   rise/fall - one-cycle pulses on a synchronized 0->1 / 1->0 change
// Pin-to-q and pin-to-pulse latency is STAGES+1 cycles.
module spi_slave_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
      q      <= RESET_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      q      <= sync_q[STAGES-1];
      // Pulses compare the newest synchronized value with the held level,
      // so they line up with the cycle in which q takes the new value.
      rise   <= sync_q[STAGES-1] & ~q;
      fall   <= ~sync_q[STAGES-1] & q;
    end
  end

endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI slave endpoint, oversampling sclk/ss/mosi on clk.
//   clk, rst              - system clock, synchronous active-high reset
//   sclk, mosi, ss        - SPI pins from the master (ss active low)
//   miso, miso_oe         - serial data to the master and its output enable
//   bus (slave modport)   - tx/rx word handshakes to user logic
//   busy                  - transfer in progress
//   rx_overrun            - pulse: unread rx word overwritten
//   tx_underrun           - pulse: word load found no TX word waiting
//   dbg_state             - FSM state, for observation only
// Words are DATA_WIDTH bits, MSB first. Back-to-back words under one ss are
// supported: each completed word re-arms a load for the next change edge.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int CLK_POLARITY = 0,
  parameter int CLK_PHASE    = 0,
  parameter int DATA_WIDTH   = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       ss,
  output logic       miso,
  output logic       miso_oe,
  spi_slave_if.slave bus,
  output logic       busy,
  output logic       rx_overrun,
  output logic       tx_underrun,
  output spi_state_t dbg_state
);

  localparam logic CPOL        = (CLK_POLARITY != 0);
  localparam logic CPHA        = (CLK_PHASE != 0);
  localparam logic SAMPLE_RISE = sample_on_rising(CPOL, CPHA);
  localparam int   CW          = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  // Synchronized pin events
  logic sclk_rise, sclk_fall, sclk_level_unused;
  logic ss_rise, ss_fall, ss_level_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_slave_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sync_sclk (
    .clk  (clk),
    .rst  (rst),
    .d    (sclk),
    .q    (sclk_level_unused),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  // ss resets to its idle (deselected) level so reset never looks like a fall.
  spi_slave_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk  (clk),
    .rst  (rst),
    .d    (ss),
    .q    (ss_level_unused),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  spi_slave_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk  (clk),
    .rst  (rst),
    .d    (mosi),
    .q    (mosi_s),
    .rise (mosi_rise_unused),
    .fall (mosi_fall_unused)
  );

  logic sample_edge, change_edge;
  assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
  assign change_edge = SAMPLE_RISE ? sclk_fall : sclk_rise;

  // FSM
  spi_state_t state_q, state_d;
  logic       start_xfer, stop_xfer, sample_act, change_act;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // A rising ss suppresses any sclk edge seen in the same cycle, so a
  // sample coinciding with deselect never completes a word.
  always_comb begin
    state_d    = state_q;
    start_xfer = 1'b0;
    stop_xfer  = 1'b0;
    sample_act = 1'b0;
    change_act = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ss_fall) begin
          state_d    = ST_ACTIVE;
          start_xfer = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (ss_rise) begin
          state_d   = ST_IDLE;
          stop_xfer = 1'b1;
        end else begin
          sample_act = sample_edge;
          change_act = change_edge;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath
  logic [DATA_WIDTH-1:0] tx_hold;
  logic                  tx_full;
  logic [DATA_WIDTH-1:0] tx_shift;
  // Only DATA_WIDTH-1 bits need storing: the last bit arrives straight
  // from mosi_s on the completing sample edge.
  logic [DATA_WIDTH-2:0] rx_shift;
  logic [DATA_WIDTH-1:0] rx_next;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  rx_valid_q;
  logic [CW-1:0]         bit_cnt;
  logic                  load_pending;
  logic                  word_load, word_done, tx_write;

  assign rx_next   = {rx_shift, mosi_s};
  assign tx_write  = bus.tx_valid && !tx_full;
  // With CPHA=0 the first bit must be on MISO before the first edge, so the
  // ss fall itself performs the load.
  assign word_load = (start_xfer && !CPHA) || (change_act && load_pending);
  assign word_done = sample_act && (bit_cnt == LAST_BIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_hold      <= '0;
      tx_full      <= 1'b0;
      tx_shift     <= '0;
      rx_shift     <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      bit_cnt      <= '0;
      load_pending <= 1'b0;
      rx_overrun   <= 1'b0;
      tx_underrun  <= 1'b0;
    end else begin
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;

      // Holding register: tx_write can only happen while empty, so a load in
      // the same cycle sees the old (empty) content and the new word stays.
      if (tx_write) begin
        tx_hold <= bus.tx_data;
        tx_full <= 1'b1;
      end else if (word_load) begin
        tx_full <= 1'b0;
      end

      if (stop_xfer) begin
        // Partial words in both directions are dropped; tx_hold is kept.
        tx_shift     <= '0;
        rx_shift     <= '0;
        bit_cnt      <= '0;
        load_pending <= 1'b0;
      end else begin
        if (start_xfer) begin
          bit_cnt      <= '0;
          rx_shift     <= '0;
          load_pending <= CPHA;
        end

        if (word_load) begin
          tx_shift    <= tx_full ? tx_hold : '0;
          tx_underrun <= !tx_full;
        end else if (change_act) begin
          tx_shift <= tx_shift << 1;
        end

        if (change_act && load_pending) load_pending <= 1'b0;

        if (sample_act) begin
          rx_shift <= rx_next[DATA_WIDTH-2:0];
          if (word_done) begin
            bit_cnt      <= '0;
            load_pending <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
      end

      // A completing word always wins over a same-cycle accept.
      if (word_done) begin
        rx_data_q  <= rx_next;
        rx_valid_q <= 1'b1;
        rx_overrun <= rx_valid_q && !bus.rx_ready;
      end else if (rx_valid_q && bus.rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign busy         = (state_q == ST_ACTIVE);
  assign miso_oe      = busy;
  assign miso         = miso_oe ? tx_shift[DATA_WIDTH-1] : 1'b0;
  assign bus.tx_ready = !tx_full;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one instance per SPI mode (index = {cpol, cpha}),
// driven by a bit-level master BFM. Expected RX words and expected MISO
// words are queued when stimulus is issued and checked as they come back.
module tb_spi_slave;
  import spi_slave_pkg::*;

  localparam int H = 8; // sclk half period / ss setup, in clk cycles

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Per-mode signals
  logic [3:0]       sclk_v, ss_v;
  logic             mosi;
  logic [3:0]       miso_v, oe_v, busy_v, ovr_v, und_v, act_v;
  logic [3:0]       tx_valid_v, tx_ready_v, rx_valid_v, rx_ready_v;
  logic [3:0][15:0] tx_data_v, rx_data_v;

  for (genvar m = 0; m < 4; m++) begin : g_dut
    spi_slave_if #(.DATA_WIDTH(16)) bus ();
    spi_state_t st;

    assign bus.tx_data     = tx_data_v[m];
    assign bus.tx_valid    = tx_valid_v[m];
    assign bus.rx_ready    = rx_ready_v[m];
    assign tx_ready_v[m]   = bus.tx_ready;
    assign rx_data_v[m]    = bus.rx_data;
    assign rx_valid_v[m]   = bus.rx_valid;
    assign act_v[m]        = (st == ST_ACTIVE);

    spi_slave #(
      .CLK_POLARITY (m / 2),
      .CLK_PHASE    (m % 2),
      .DATA_WIDTH   (16),
      .SYNC_STAGES  (2)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .sclk        (sclk_v[m]),
      .mosi        (mosi),
      .ss          (ss_v[m]),
      .miso        (miso_v[m]),
      .miso_oe     (oe_v[m]),
      .bus         (bus),
      .busy        (busy_v[m]),
      .rx_overrun  (ovr_v[m]),
      .tx_underrun (und_v[m]),
      .dbg_state   (st)
    );
  end

  // Scoreboard
  int          checks = 0;
  int          errors = 0;
  int          cur_m  = 0;
  int          ovr_cnt = 0;
  int          und_cnt = 0;
  logic [15:0] exp_q[$];      // expected rx_data words
  logic [15:0] exp_miso_q[$]; // expected words read by the master
  logic [15:0] exp_w;

  always @(negedge clk) begin
    if (!rst) begin
      if (ovr_v[cur_m]) ovr_cnt++;
      if (und_v[cur_m]) und_cnt++;
      if (rx_valid_v[cur_m] && rx_ready_v[cur_m]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected mode %0d got %h expected none", cur_m, rx_data_v[cur_m]);
        end else begin
          exp_w = exp_q.pop_front();
          if (rx_data_v[cur_m] !== exp_w) begin
            errors++;
            $display("FAIL rx_data mode %0d got %h expected %h", cur_m, rx_data_v[cur_m], exp_w);
          end
        end
      end
    end
  end

  // Driver tasks
  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic preload(input int m, input logic [15:0] w, input bit push);
    int i;
    i = 0;
    while (!tx_ready_v[m] && i < 50) begin
      clks(1);
      i++;
    end
    checks++;
    if (tx_ready_v[m] !== 1'b1) begin
      errors++;
      $display("FAIL tx_ready_wait mode %0d got %b expected 1", m, tx_ready_v[m]);
    end
    tx_data_v[m]  = w;
    tx_valid_v[m] = 1'b1;
    clks(1);
    tx_valid_v[m] = 1'b0;
    if (push) exp_miso_q.push_back(w);
  endtask

  task automatic ss_low(input int m);
    ss_v[m] = 1'b0;
    clks(H);
    checks++;
    if (busy_v[m] !== 1'b1 || oe_v[m] !== 1'b1) begin
      errors++;
      $display("FAIL busy_on mode %0d got busy=%b oe=%b expected 1/1", m, busy_v[m], oe_v[m]);
    end
  endtask

  task automatic ss_high(input int m);
    clks(H);
    ss_v[m] = 1'b1;
    clks(H);
    checks++;
    if (busy_v[m] !== 1'b0 || act_v[m] !== 1'b0 || oe_v[m] !== 1'b0) begin
      errors++;
      $display("FAIL busy_off mode %0d got busy=%b active=%b oe=%b expected 0/0/0",
               m, busy_v[m], act_v[m], oe_v[m]);
    end
  endtask

  task automatic spi_bit(input int m, input logic b_out, output logic b_in);
    if ((m % 2) == 0) begin
      mosi = b_out;
      clks(H);
      b_in = miso_v[m];
      sclk_v[m] = ~sclk_v[m];
      clks(H);
      sclk_v[m] = ~sclk_v[m];
    end else begin
      sclk_v[m] = ~sclk_v[m];
      mosi = b_out;
      clks(H);
      b_in = miso_v[m];
      sclk_v[m] = ~sclk_v[m];
      clks(H);
    end
  endtask

  task automatic spi_word(input int m, input logic [15:0] w, input int nbits, input bit chk);
    logic [15:0] rd;
    logic        b;
    rd = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_bit(m, w[15-i], b);
      rd = {rd[14:0], b};
    end
    if (chk) begin
      checks++;
      if (exp_miso_q.size() == 0) begin
        errors++;
        $display("FAIL miso_unexpected mode %0d got %h expected none", m, rd);
      end else begin
        exp_w = exp_miso_q.pop_front();
        if (rd !== exp_w) begin
          errors++;
          $display("FAIL miso_word mode %0d got %h expected %h", m, rd, exp_w);
        end
      end
    end
  endtask

  // Tests
  task automatic test_reset;
    rst = 1'b1;
    clks(3);
    checks++;
    if ({tx_ready_v, rx_valid_v, busy_v, miso_v, oe_v, ovr_v, und_v, act_v} !== {4'hF, 28'h0}) begin
      errors++;
      $display("FAIL reset_flags got %h expected %h",
               {tx_ready_v, rx_valid_v, busy_v, miso_v, oe_v, ovr_v, und_v, act_v}, {4'hF, 28'h0});
    end
    checks++;
    if (rx_data_v !== '0) begin
      errors++;
      $display("FAIL reset_rx_data got %h expected 0", rx_data_v);
    end
    rst = 1'b0;
    clks(2);
  endtask

  task automatic test_mode0;
    cur_m = 0;
    preload(0, 16'hA55A, 1'b1);
    exp_q.push_back(16'h1234);
    ss_v[0] = 1'b0;
    clks(3);
    checks++;
    if (oe_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL oe_latency_early got %b expected 0", oe_v[0]);
    end
    clks(1);
    checks++;
    if (oe_v[0] !== 1'b1 || miso_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL miso_msb_latency got oe=%b miso=%b expected 1/1", oe_v[0], miso_v[0]);
    end
    clks(H - 4);
    spi_word(0, 16'h1234, 16, 1'b1);
    ss_high(0);
    clks(4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL mode0_rx_missing got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_all_modes;
    for (int m = 0; m < 4; m++) begin
      cur_m = m;
      preload(m, 16'h0F0F, 1'b1);
      exp_q.push_back(16'hBEEF);
      ss_low(m);
      spi_word(m, 16'hBEEF, 16, 1'b1);
      ss_high(m);
      clks(4);
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL modes_rx_missing mode %0d got %0d pending expected 0", m, exp_q.size());
      end
    end
  endtask

  task automatic test_back_to_back;
    int mlist[2];
    mlist = '{0, 3};
    for (int k = 0; k < 2; k++) begin
      cur_m = mlist[k];
      preload(cur_m, 16'h1111, 1'b1);
      exp_q.push_back(16'h0001);
      exp_q.push_back(16'h8000);
      ss_low(cur_m);
      fork
        spi_word(cur_m, 16'h0001, 16, 1'b1);
        preload(cur_m, 16'h2222, 1'b1);
      join
      spi_word(cur_m, 16'h8000, 16, 1'b1);
      ss_high(cur_m);
      clks(4);
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL b2b_rx_missing mode %0d got %0d pending expected 0", cur_m, exp_q.size());
      end
    end
  endtask

  task automatic test_underrun;
    cur_m = 1;
    clks(2);
    und_cnt = 0;
    exp_miso_q.push_back(16'h0000);
    exp_q.push_back(16'h3C3C);
    ss_low(1);
    spi_word(1, 16'h3C3C, 16, 1'b1);
    ss_high(1);
    clks(4);
    checks++;
    if (und_cnt != 1) begin
      errors++;
      $display("FAIL underrun_count got %0d expected 1", und_cnt);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL underrun_rx_missing got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_overrun;
    cur_m = 1;
    rx_ready_v[1] = 1'b0;
    clks(2);
    ovr_cnt = 0;
    ss_low(1);
    spi_word(1, 16'h1357, 16, 1'b0);
    spi_word(1, 16'h2468, 16, 1'b0);
    ss_high(1);
    checks++;
    if (ovr_cnt != 1) begin
      errors++;
      $display("FAIL overrun_count got %0d expected 1", ovr_cnt);
    end
    checks++;
    if (rx_valid_v[1] !== 1'b1 || rx_data_v[1] !== 16'h2468) begin
      errors++;
      $display("FAIL overrun_hold got valid=%b data=%h expected 1/2468", rx_valid_v[1], rx_data_v[1]);
    end
    exp_q.push_back(16'h2468);
    rx_ready_v[1] = 1'b1;
    clks(3);
    checks++;
    if (exp_q.size() != 0 || rx_valid_v[1] !== 1'b0) begin
      errors++;
      $display("FAIL overrun_drain got pending=%0d valid=%b expected 0/0", exp_q.size(), rx_valid_v[1]);
    end
  endtask

  task automatic test_ss_abort;
    cur_m = 0;
    preload(0, 16'h1357, 1'b0);
    ss_low(0);
    spi_word(0, 16'hFFFF, 7, 1'b0);
    ss_high(0);
    clks(4);
    checks++;
    if (rx_valid_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_rx_valid got %b expected 0", rx_valid_v[0]);
    end
    preload(0, 16'h6E6E, 1'b1);
    exp_q.push_back(16'hCAFE);
    ss_low(0);
    spi_word(0, 16'hCAFE, 16, 1'b1);
    ss_high(0);
    clks(4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_next_rx_missing got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid;
    cur_m = 0;
    preload(0, 16'h1111, 1'b0);
    ss_low(0);
    preload(0, 16'h2222, 1'b0);
    spi_word(0, 16'h00FF, 5, 1'b0);
    rst = 1'b1;
    ss_v[0] = 1'b1;
    clks(1);
    checks++;
    if ({tx_ready_v[0], rx_valid_v[0], busy_v[0], oe_v[0], miso_v[0], act_v[0], ovr_v[0], und_v[0]}
        !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset_mid got %b expected 10000000",
               {tx_ready_v[0], rx_valid_v[0], busy_v[0], oe_v[0], miso_v[0], act_v[0], ovr_v[0], und_v[0]});
    end
    clks(2);
    rst = 1'b0;
    clks(4);
    preload(0, 16'hA5A5, 1'b1);
    exp_q.push_back(16'h5A5A);
    ss_low(0);
    spi_word(0, 16'h5A5A, 16, 1'b1);
    ss_high(0);
    clks(4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_next_rx_missing got %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    rst        = 1'b1;
    sclk_v     = 4'b1100;
    ss_v       = 4'hF;
    mosi       = 1'b0;
    tx_valid_v = '0;
    tx_data_v  = '0;
    rx_ready_v = 4'hF;
    test_reset();
    test_mode0();
    test_all_modes();
    test_back_to_back();
    test_underrun();
    test_overrun();
    test_ss_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired before end of test sequence");
    $fatal(1, "simulation time limit reached");
  end

endmodule
